monitor_rx: RTL and testbench
=============================

# monitor_rx

Receive-side counterpart of the transmit timestamp inserter in the monitor NIC pipeline. It sits in the user data path of the receiving NetFPGA and passes packets through unmodified, or with the stamp scrubbed. From each packet it extracts the 64-bit transmit timestamp embedded in payload words 5–6 and the IP identification field. It computes one-way latency against the local `timestamp` bus and publishes per-packet and aggregate latency statistics through the register chain.

## Interface
Parameters:
- `DATA_WIDTH`, 64: datapath width.
- `CTRL_WIDTH`, `DATA_WIDTH/8`: control width.
- `UDP_REG_SRC_WIDTH`, 2: register source tag width.
- `SCRUB_STAMP`, 0: when 1, zero the embedded stamp bits on output.

Ports:
- `clk` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-high.
- `in_data` in `DATA_WIDTH`: input word.
- `in_ctrl` in `CTRL_WIDTH`: input control; 0 marks a data word.
- `in_wr` in 1: input word valid.
- `in_rdy` out 1: upstream may write.
- `out_data` out `DATA_WIDTH`: output word.
- `out_ctrl` out `CTRL_WIDTH`: output control.
- `out_wr` out 1: output word valid.
- `out_rdy` in 1: downstream may accept.
- `timestamp` in 64: free-running local time, same format as the sender's.
- `reg_req_in`, `reg_ack_in`, `reg_rd_wr_L_in` in 1 each: register chain input.
- `reg_addr_in` in `UDP_REG_ADDR_WIDTH`: register chain input.
- `reg_data_in` in `CPCI_NF2_DATA_WIDTH`: register chain input.
- `reg_src_in` in `UDP_REG_SRC_WIDTH`: register chain input.
- `reg_*_out` out, same widths: register chain output.
- Registers are implemented with `generic_regs`, TAG `MONITOR_RX_BLOCK_ADDR`, 1 software reg, 7 hardware regs.

## Operation
- Input buffering: `fallthrough_small_fifo`, depth 4, width CTRL+DATA. `in_rdy = !nearly_full`.
- Word transfer: occurs when the FIFO is not empty and `out_rdy` is high. On a transfer, `out_wr=1`, `rd_en=1`, and the output equals the FIFO head. Otherwise `out_wr=0`.
- Word index `w`:
  - The first `ctrl==0` word is w=1.
  - Module header words (`ctrl!=0` before w=1) pass through untouched.
- State machine (one-hot):
  - HDR: pass control words. On a transfer of a `ctrl==0` word, latch `rx_time=timestamp` and go to IPHDR with w=2 next.
  - IPHDR: words 2–4. At w=2, latch `ip_id_tmp=data[47:32]`. At w=4, go to STAMP_HI.
  - STAMP_HI: word 5. Latch `stamp[63:16]=data[47:0]`. Go to STAMP_LO.
  - STAMP_LO: word 6. `stamp[15:0]=data[63:48]`. Commit statistics on this transfer. If `ctrl!=0`, go to HDR; else go to BODY.
  - BODY: pass words. On a `ctrl!=0` word (EOP), go to HDR.
- Short packet: an EOP (`ctrl!=0`) transferred in IPHDR, STAMP_HI, or BODY-before-w6 returns to HDR. It increments `short_pkt_count` and commits no latency stats.
- Scrub: if `SCRUB_STAMP=1`, `out_data[47:0]` is zeroed at w=5 and `out_data[63:48]` is zeroed at w=6. `out_ctrl` is never modified.
- Latency: `lat = rx_time - {stamp[63:16], data[63:48]}`, modulo 2^64. Negative results wrap; no special handling.
- `lat32`: `lat[31:0]` if `lat[63:32]==0`, else `32'hFFFFFFFF` (saturate).
- Commit:
  - `pkt_count++` (32-bit, wraps).
  - `last_ip_id <= ip_id_tmp`.
  - `last_lat <= lat`.
  - `min <= min(min, lat32)`.
  - `max <= max(max, lat32)`.
- Hardware registers, in address order:
  - 0 `pkt_count`.
  - 1 `{16'h0, last_ip_id}`.
  - 2 `last_lat[31:0]`.
  - 3 `last_lat[63:32]`.
  - 4 `min_lat`.
  - 5 `max_lat`.
  - 6 `short_pkt_count`.
- Software reg 0, bit0 = clear: while set, all stats are held at reset values.

## Timing
- Reset values:
  - State HDR, w=1.
  - FIFO empty, so `out_wr=0` and `in_rdy=1`.
  - `pkt_count`, `short_pkt_count`, `last_*`, `max_lat` = 0.
  - `min_lat = 32'hFFFFFFFF`.
  - Software reg = 0.
- Latency: zero added cycles beyond the FIFO. A word written at cycle t is presented at t+1 (fallthrough).
- Back-pressure: `out_rdy=0` stalls the state machine with no state or stat change. Data is never dropped while `in_rdy` is honoured.
- Stat registers update on the clock edge of the w=6 transfer and are readable from the next cycle.
- `rx_time` is sampled on the cycle w=1 transfers, not when it enters the FIFO.
- Clear and commit in the same cycle: clear wins.
- Reset mid-packet: returns to HDR immediately. The remainder of the interrupted packet after reset is treated as a new packet; the bench must not rely on its stats.
- A packet with `ctrl!=0` exactly on w=6 is a full packet: commit, then go to HDR.

## Test plan
- Stamped packet:
  - Stimulus: 1 ctrl header, w2[47:32]=16'h1234, stamp 64'h0000_0001_0000_0100, `timestamp=64'h0000_0001_0000_0164` at w1, 8 data words.
  - Response: output bit-identical; `pkt_count=1`, `last_ip_id=1234`, `last_lat_lo=0x64`, `last_lat_hi=0`, `min=max=0x64`.
- Min/max tracking:
  - Stimulus: latencies 0x100, 0x40, 0x200 in three packets.
  - Response: `min=0x40`, `max=0x200`, `pkt_count=3`, `last_lat_lo=0x200`.
- Short and saturating packets:
  - Stimulus: EOP at w=4.
  - Response: `short_pkt_count=1`, other stats unchanged; the next full packet is parsed correctly.
  - Stimulus: latency 64'h1_0000_0000.
  - Response: `min`/`max` = FFFFFFFF, `last_lat_hi=1`.
- Scrub and back-pressure:
  - Stimulus: `SCRUB_STAMP=1`, random `out_rdy` at 50%.
  - Response: w5[47:0]=0 and w6[63:48]=0; all other bits match; no loss or duplication; `in_rdy` deasserts at nearly_full.
- Clear and reset:
  - Stimulus: write sw reg=1 during a w=6 transfer, then write 0.
  - Response: stats at reset values, including `min=FFFFFFFF`.
  - Stimulus: assert `reset` at w=3.
  - Response: `out_wr=0` immediately, FIFO empty, stats at reset values.

Source files
------------

// File: rtl/monitor_rx.sv
// monitor_rx: receive-side latency monitor. Passes packets through (optionally
// scrubbing the embedded transmit stamp), extracts the 64-bit stamp from payload
// words 5-6 plus the IP identification field, and publishes per-packet and
// aggregate one-way latency statistics on the register chain.
//
// Register map (low three address bits, upper bits must equal the block tag):
//   0 software reg (bit0 = clear), 1 pkt_count, 2 {16'h0, last_ip_id},
//   3 last_lat[31:0], 4 last_lat[63:32], 5 min_lat, 6 max_lat, 7 short_pkt_count
//
// state      | meaning
// S_HDR      | passing module header words, waiting for the first data word (w=1)
// S_IPHDR    | data words 2..4; IP identification captured at w=2
// S_STAMP_HI | word 5, carries stamp[63:16] in data[47:0]
// S_STAMP_LO | word 6, carries stamp[15:0] in data[63:48]; stats commit here
// S_BODY     | remaining payload until the EOP word
module monitor_rx #(
  parameter int DATA_WIDTH            = 64,
  parameter int CTRL_WIDTH            = DATA_WIDTH/8,
  parameter int UDP_REG_SRC_WIDTH     = 2,
  parameter int SCRUB_STAMP           = 0,
  parameter int UDP_REG_ADDR_WIDTH    = 23,
  parameter int CPCI_NF2_DATA_WIDTH   = 32,
  parameter int MONITOR_RX_BLOCK_ADDR = 'h42
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic [CTRL_WIDTH-1:0]          in_ctrl,
  input  logic                           in_wr,
  output logic                           in_rdy,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [CTRL_WIDTH-1:0]          out_ctrl,
  output logic                           out_wr,
  input  logic                           out_rdy,
  input  logic [63:0]                    timestamp,
  input  logic                           reg_req_in,
  input  logic                           reg_ack_in,
  input  logic                           reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in,
  output logic                           reg_req_out,
  output logic                           reg_ack_out,
  output logic                           reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out
);

  localparam int FW    = CTRL_WIDTH + DATA_WIDTH;
  localparam int TAG_W = UDP_REG_ADDR_WIDTH - 3;
  localparam logic [TAG_W-1:0] L_TAG = TAG_W'(MONITOR_RX_BLOCK_ADDR);

  typedef enum logic [4:0] {
    S_HDR      = 5'b00001,
    S_IPHDR    = 5'b00010,
    S_STAMP_HI = 5'b00100,
    S_STAMP_LO = 5'b01000,
    S_BODY     = 5'b10000
  } state_t;

  // ---------------- input FIFO (fallthrough, depth 4) ----------------
  logic [FW-1:0]         r_mem [4];
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_rd_ptr;
  logic [2:0]            r_count;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_wr;
  logic                  w_xfer;
  logic [FW-1:0]         w_head;
  logic [CTRL_WIDTH-1:0] w_head_ctrl;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_is_data;

  assign w_empty     = (r_count == 3'd0);
  assign w_full      = (r_count == 3'd4);
  assign in_rdy      = (r_count < 3'd3);
  assign w_wr        = in_wr && !w_full;
  assign w_xfer      = !w_empty && out_rdy;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_ctrl = w_head[FW-1:DATA_WIDTH];
  assign w_head_data = w_head[DATA_WIDTH-1:0];
  assign w_is_data   = (w_head_ctrl == '0);

  // FIFO storage; contents need no reset because r_count gates visibility
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {in_ctrl, in_data};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_wr)   r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_xfer) r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_wr, w_xfer})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- parser FSM ----------------
  state_t r_state;
  state_t w_state_nxt;
  logic [2:0] r_w;
  logic [2:0] w_w_nxt;
  logic w_take_rx;
  logic w_take_id;
  logic w_take_hi;
  logic w_commit;
  logic w_short;

  // state and word index register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_HDR;
      r_w     <= 3'd1;
    end else begin
      r_state <= w_state_nxt;
      r_w     <= w_w_nxt;
    end
  end

  // next-state decode and capture/commit strobes; nothing moves without a transfer
  always_comb begin
    w_state_nxt = r_state;
    w_w_nxt     = r_w;
    w_take_rx   = 1'b0;
    w_take_id   = 1'b0;
    w_take_hi   = 1'b0;
    w_commit    = 1'b0;
    w_short     = 1'b0;
    case (r_state)
      S_HDR: begin
        if (w_xfer && w_is_data) begin
          w_take_rx   = 1'b1;
          w_state_nxt = S_IPHDR;
          w_w_nxt     = 3'd2;
        end
      end
      S_IPHDR: begin
        if (w_xfer) begin
          if (!w_is_data) begin
            w_short     = 1'b1;
            w_state_nxt = S_HDR;
            w_w_nxt     = 3'd1;
          end else begin
            if (r_w == 3'd2) w_take_id = 1'b1;
            if (r_w == 3'd4) begin
              w_state_nxt = S_STAMP_HI;
              w_w_nxt     = 3'd5;
            end else begin
              w_w_nxt = r_w + 3'd1;
            end
          end
        end
      end
      S_STAMP_HI: begin
        if (w_xfer) begin
          if (!w_is_data) begin
            w_short     = 1'b1;
            w_state_nxt = S_HDR;
            w_w_nxt     = 3'd1;
          end else begin
            w_take_hi   = 1'b1;
            w_state_nxt = S_STAMP_LO;
            w_w_nxt     = 3'd6;
          end
        end
      end
      S_STAMP_LO: begin
        if (w_xfer) begin
          w_commit = 1'b1;
          if (!w_is_data) begin
            w_state_nxt = S_HDR;
            w_w_nxt     = 3'd1;
          end else begin
            w_state_nxt = S_BODY;
            w_w_nxt     = 3'd7;
          end
        end
      end
      S_BODY: begin
        if (w_xfer && !w_is_data) begin
          w_state_nxt = S_HDR;
          w_w_nxt     = 3'd1;
        end
      end
      default: begin
        w_state_nxt = S_HDR;
        w_w_nxt     = 3'd1;
      end
    endcase
  end

  // ---------------- output path ----------------
  logic [DATA_WIDTH-1:0] w_out_data;

  // stamp scrub on words 5 and 6; control is never touched
  always_comb begin
    w_out_data = w_head_data;
    if (SCRUB_STAMP != 0) begin
      if (r_state == S_STAMP_HI) w_out_data[47:0]  = '0;
      if (r_state == S_STAMP_LO) w_out_data[63:48] = '0;
    end
  end

  assign out_data = w_out_data;
  assign out_ctrl = w_head_ctrl;
  assign out_wr   = w_xfer;

  // ---------------- capture and statistics ----------------
  logic [63:0] r_rx_time;
  logic [15:0] r_ip_id_tmp;
  logic [47:0] r_stamp_hi;
  logic [63:0] w_lat;
  logic [31:0] w_lat32;
  logic [31:0] r_pkt_count;
  logic [31:0] r_short_count;
  logic [15:0] r_last_ip_id;
  logic [63:0] r_last_lat;
  logic [31:0] r_min_lat;
  logic [31:0] r_max_lat;
  logic [CPCI_NF2_DATA_WIDTH-1:0] r_sw_reg;

  // low stamp half comes straight from the w=6 head word so commit needs no extra cycle
  assign w_lat   = r_rx_time - {r_stamp_hi, w_head_data[63:48]};
  assign w_lat32 = (w_lat[63:32] == 32'd0) ? w_lat[31:0] : 32'hFFFF_FFFF;

  // per-packet capture: arrival time at w=1, IP id at w=2, stamp high at w=5
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_time   <= 64'd0;
      r_ip_id_tmp <= 16'd0;
      r_stamp_hi  <= 48'd0;
    end else begin
      if (w_take_rx) r_rx_time   <= timestamp;
      if (w_take_id) r_ip_id_tmp <= w_head_data[47:32];
      if (w_take_hi) r_stamp_hi  <= w_head_data[47:0];
    end
  end

  // statistics; a set clear bit overrides any commit in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pkt_count   <= 32'd0;
      r_short_count <= 32'd0;
      r_last_ip_id  <= 16'd0;
      r_last_lat    <= 64'd0;
      r_min_lat     <= 32'hFFFF_FFFF;
      r_max_lat     <= 32'd0;
    end else if (r_sw_reg[0]) begin
      r_pkt_count   <= 32'd0;
      r_short_count <= 32'd0;
      r_last_ip_id  <= 16'd0;
      r_last_lat    <= 64'd0;
      r_min_lat     <= 32'hFFFF_FFFF;
      r_max_lat     <= 32'd0;
    end else begin
      if (w_commit) begin
        r_pkt_count  <= r_pkt_count + 32'd1;
        r_last_ip_id <= r_ip_id_tmp;
        r_last_lat   <= w_lat;
        if (w_lat32 < r_min_lat) r_min_lat <= w_lat32;
        if (w_lat32 > r_max_lat) r_max_lat <= w_lat32;
      end
      if (w_short) r_short_count <= r_short_count + 32'd1;
    end
  end

  // ---------------- register chain node ----------------
  logic                           w_hit;
  logic [CPCI_NF2_DATA_WIDTH-1:0] w_rd_data;

  assign w_hit = reg_req_in && !reg_ack_in &&
                 (reg_addr_in[UDP_REG_ADDR_WIDTH-1:3] == L_TAG);

  // read-data select by register index
  always_comb begin
    w_rd_data = '0;
    case (reg_addr_in[2:0])
      3'd0: w_rd_data = r_sw_reg;
      3'd1: w_rd_data = CPCI_NF2_DATA_WIDTH'(r_pkt_count);
      3'd2: w_rd_data = CPCI_NF2_DATA_WIDTH'({16'h0, r_last_ip_id});
      3'd3: w_rd_data = CPCI_NF2_DATA_WIDTH'(r_last_lat[31:0]);
      3'd4: w_rd_data = CPCI_NF2_DATA_WIDTH'(r_last_lat[63:32]);
      3'd5: w_rd_data = CPCI_NF2_DATA_WIDTH'(r_min_lat);
      3'd6: w_rd_data = CPCI_NF2_DATA_WIDTH'(r_max_lat);
      default: w_rd_data = CPCI_NF2_DATA_WIDTH'(r_short_count);
    endcase
  end

  // one-cycle forwarding stage; claims requests addressed to this block
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b1;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
      r_sw_reg        <= '0;
    end else begin
      reg_req_out     <= reg_req_in;
      reg_rd_wr_L_out <= reg_rd_wr_L_in;
      reg_addr_out    <= reg_addr_in;
      reg_src_out     <= reg_src_in;
      if (w_hit) begin
        reg_ack_out  <= 1'b1;
        reg_data_out <= reg_rd_wr_L_in ? w_rd_data : reg_data_in;
        if (!reg_rd_wr_L_in && reg_addr_in[2:0] == 3'd0) r_sw_reg <= reg_data_in;
      end else begin
        reg_ack_out  <= reg_ack_in;
        reg_data_out <= reg_data_in;
      end
    end
  end

endmodule

// File: tb/tb_monitor_rx.sv
// tb_monitor_rx: directed bench for monitor_rx. Two instances share stimulus:
// u_dut passes data unmodified, u_dut_s scrubs the stamp. Statistics are read
// back over the register chain of u_dut and compared to a hand-computed table.
module tb_monitor_rx;

  localparam logic [19:0] TAG = 20'h00042;

  logic        clk;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        out_rdy;
  logic [63:0] timestamp;
  logic        reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [22:0] reg_addr_in;
  logic [31:0] reg_data_in;
  logic [1:0]  reg_src_in;

  logic        in_rdy, out_wr;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [22:0] reg_addr_out;
  logic [31:0] reg_data_out;
  logic [1:0]  reg_src_out;

  logic        s_in_rdy, s_out_wr;
  logic [63:0] s_out_data;
  logic [7:0]  s_out_ctrl;
  logic        s_req_out, s_ack_out, s_rd_wr_L_out;
  logic [22:0] s_addr_out;
  logic [31:0] s_data_out;
  logic [1:0]  s_src_out;

  monitor_rx #(.SCRUB_STAMP(0)) u_dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .timestamp(timestamp),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out)
  );

  monitor_rx #(.SCRUB_STAMP(1)) u_dut_s (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(s_in_rdy),
    .out_data(s_out_data), .out_ctrl(s_out_ctrl), .out_wr(s_out_wr), .out_rdy(out_rdy),
    .timestamp(timestamp),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(s_req_out), .reg_ack_out(s_ack_out), .reg_rd_wr_L_out(s_rd_wr_L_out),
    .reg_addr_out(s_addr_out), .reg_data_out(s_data_out), .reg_src_out(s_src_out)
  );

  typedef struct {
    logic [15:0] ip;
    logic [63:0] stamp;
    logic [63:0] ts;
    int          n;
    bit          clr;
    logic [31:0] e_pkt, e_ip, e_lo, e_hi, e_min, e_max, e_short;
  } vec_t;

  vec_t        vecs[8];
  logic [71:0] q0[$];
  logic [71:0] q1[$];
  logic [71:0] m_e0, m_e1;
  logic [31:0] rd;
  int          total = 0;
  int          bad = 0;
  int          rdy_mode = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [71:0] a, input logic [71:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endfunction

  // out_rdy: 0 -> always ready, 1 -> random 50%, 2 -> stalled
  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = 1'($urandom_range(0, 1));
        default: out_rdy = 1'b0;
      endcase
    end
  end

  // output scoreboards for both instances
  always @(negedge clk) begin
    if (!reset) begin
      if (out_wr) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL out0_extra actual=%h required=no_word", {out_ctrl, out_data});
        end else begin
          m_e0 = q0.pop_front();
          chk("out0_word", {out_ctrl, out_data}, m_e0);
        end
      end
      if (s_out_wr) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL out1_extra actual=%h required=no_word", {s_out_ctrl, s_out_data});
        end else begin
          m_e1 = q1.pop_front();
          chk("out1_word", {s_out_ctrl, s_out_data}, m_e1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic [7:0] c, input logic [63:0] d, input int k);
    int n = 0;
    logic [63:0] ds;
    while (!in_rdy && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_rdy) begin
      total++; bad++;
      $display("FAIL in_rdy_timeout actual=0 required=1");
    end
    ds = d;
    if (k == 5) ds[47:0]  = 48'h0;
    if (k == 6) ds[63:48] = 16'h0;
    q0.push_back({c, d});
    q1.push_back({c, ds});
    in_ctrl = c; in_data = d; in_wr = 1'b1;
    @(posedge clk); #1;
    in_wr = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin @(posedge clk); #1; n++; end
    chk("drain_q0", 72'(q0.size()), 72'd0);
    chk("drain_q1", 72'(q1.size()), 72'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic send_pkt(input logic [15:0] ip, input logic [63:0] stamp,
                          input logic [63:0] ts, input int n, input bit stall);
    logic [63:0] d;
    logic [7:0]  c;
    timestamp = ts;
    if (stall) begin
      rdy_mode = 2;
      repeat (3) begin @(posedge clk); #1; end
    end
    send_word(8'hFF, {$urandom, $urandom}, 0);
    for (int k = 1; k <= n; k++) begin
      d = {$urandom, $urandom};
      c = (k == n) ? 8'h01 : 8'h00;
      if (k == 2) d[47:32] = ip;
      if (k == 5) d[47:0]  = stamp[63:16];
      if (k == 6) d[63:48] = stamp[15:0];
      send_word(c, d, k);
      if (stall && k == 1) chk("stall_in_rdy_hi", 72'(in_rdy), 72'd1);
      if (stall && k == 2) begin
        chk("stall_in_rdy_lo", 72'(in_rdy), 72'd0);
        rdy_mode = 0;
      end
    end
    drain();
  endtask

  task automatic reg_access(input logic rdl, input logic [2:0] idx,
                            input logic [31:0] wd, output logic [31:0] rdata);
    int n = 0;
    reg_req_in = 1'b1; reg_rd_wr_L_in = rdl; reg_addr_in = {TAG, idx}; reg_data_in = wd;
    @(posedge clk); #1;
    reg_req_in = 1'b0;
    while (!reg_ack_out && n < 4) begin @(posedge clk); #1; n++; end
    if (!reg_ack_out) begin
      total++; bad++;
      $display("FAIL reg_ack_timeout idx=%0d actual=0 required=1", idx);
    end
    rdata = reg_data_out;
    @(posedge clk); #1;
  endtask

  task automatic check_stats(input string t, input logic [31:0] e_pkt, e_ip, e_lo,
                             e_hi, e_min, e_max, e_short);
    logic [31:0] r;
    reg_access(1'b1, 3'd1, 32'h0, r); chk({t, "_pkt"},   72'(r), 72'(e_pkt));
    reg_access(1'b1, 3'd2, 32'h0, r); chk({t, "_ip"},    72'(r), 72'(e_ip));
    reg_access(1'b1, 3'd3, 32'h0, r); chk({t, "_latlo"}, 72'(r), 72'(e_lo));
    reg_access(1'b1, 3'd4, 32'h0, r); chk({t, "_lathi"}, 72'(r), 72'(e_hi));
    reg_access(1'b1, 3'd5, 32'h0, r); chk({t, "_min"},   72'(r), 72'(e_min));
    reg_access(1'b1, 3'd6, 32'h0, r); chk({t, "_max"},   72'(r), 72'(e_max));
    reg_access(1'b1, 3'd7, 32'h0, r); chk({t, "_short"}, 72'(r), 72'(e_short));
  endtask

  initial begin
    reset = 1'b1; in_wr = 1'b0; in_ctrl = 8'h0; in_data = 64'h0; timestamp = 64'h0;
    reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b1;
    reg_addr_in = 23'h0; reg_data_in = 32'h0; reg_src_in = 2'b0;

    //             ip      stamp                      ts                         n  clr pkt ip       lo            hi            min           max           short
    vecs[0] = '{16'h1234, 64'h0000_0001_0000_0100, 64'h0000_0001_0000_0164, 8, 1'b0, 32'd1, 32'h1234, 32'h64,       32'h0,        32'h64,       32'h64,       32'd0};
    vecs[1] = '{16'h0001, 64'h1000,                64'h1100,                8, 1'b1, 32'd1, 32'h0001, 32'h100,      32'h0,        32'h100,      32'h100,      32'd0};
    vecs[2] = '{16'h0002, 64'h2000,                64'h2040,                7, 1'b0, 32'd2, 32'h0002, 32'h40,       32'h0,        32'h40,       32'h100,      32'd0};
    vecs[3] = '{16'h0003, 64'h3000,                64'h3200,               10, 1'b0, 32'd3, 32'h0003, 32'h200,      32'h0,        32'h40,       32'h200,      32'd0};
    vecs[4] = '{16'h0004, 64'h4000,                64'h4000,                4, 1'b0, 32'd3, 32'h0003, 32'h200,      32'h0,        32'h40,       32'h200,      32'd1};
    vecs[5] = '{16'h0005, 64'hABCD_0000_1234_5678, 64'hABCD_0000_1234_56F8, 6, 1'b0, 32'd4, 32'h0005, 32'h80,       32'h0,        32'h40,       32'h200,      32'd1};
    vecs[6] = '{16'h0006, 64'h10,                  64'h1_0000_0010,         8, 1'b1, 32'd1, 32'h0006, 32'h0,        32'h1,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    vecs[7] = '{16'h0007, 64'h200,                 64'h100,                 8, 1'b0, 32'd2, 32'h0007, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    chk("rst_out_wr", 72'(out_wr), 72'd0);
    chk("rst_in_rdy", 72'(in_rdy), 72'd1);
    reg_access(1'b1, 3'd0, 32'h0, rd); chk("rst_sw", 72'(rd), 72'd0);
    check_stats("rst", 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].clr) begin
        reg_access(1'b0, 3'd0, 32'h1, rd);
        reg_access(1'b0, 3'd0, 32'h0, rd);
      end
      send_pkt(vecs[i].ip, vecs[i].stamp, vecs[i].ts, vecs[i].n, 1'b0);
      check_stats($sformatf("v%0d", i), vecs[i].e_pkt, vecs[i].e_ip, vecs[i].e_lo,
                  vecs[i].e_hi, vecs[i].e_min, vecs[i].e_max, vecs[i].e_short);
    end

    // clear held across a committing packet, then released
    reg_access(1'b0, 3'd0, 32'h1, rd);
    reg_access(1'b1, 3'd0, 32'h0, rd); chk("clr_sw_set", 72'(rd), 72'd1);
    send_pkt(16'h0008, 64'h0, 64'h55, 8, 1'b0);
    check_stats("clr_hold", 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);
    reg_access(1'b0, 3'd0, 32'h0, rd);
    reg_access(1'b1, 3'd0, 32'h0, rd); chk("clr_sw_rel", 72'(rd), 72'd0);
    check_stats("clr_rel", 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);
    send_pkt(16'h0009, 64'h100, 64'h130, 8, 1'b0);
    check_stats("after_clr", 32'd1, 32'h9, 32'h30, 32'd0, 32'h30, 32'h30, 32'd0);

    // nearly-full back-pressure, then random out_rdy with scrubbing checked on u_dut_s
    send_pkt(16'h00A1, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4544, 9, 1'b1);
    rdy_mode = 1;
    send_pkt(16'h00A2, 64'h0, 64'h10, 12, 1'b0);
    rdy_mode = 0;
    repeat (2) begin @(posedge clk); #1; end
    check_stats("bp", 32'd3, 32'hA2, 32'h10, 32'd0, 32'h10, 32'h100, 32'd0);

    // reset while word 3 is presented
    timestamp = 64'h777;
    send_word(8'hFF, 64'h1, 0);
    send_word(8'h00, 64'h2, 1);
    send_word(8'h00, 64'h3, 2);
    send_word(8'h00, 64'h4, 3);
    chk("pre_rst_out_wr", 72'(out_wr), 72'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_wr", 72'(out_wr), 72'd0);
    chk("mid_rst_in_rdy", 72'(in_rdy), 72'd1);
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("post_rst_out_wr", 72'(out_wr), 72'd0);
    reg_access(1'b1, 3'd0, 32'h0, rd); chk("post_rst_sw", 72'(rd), 72'd0);
    check_stats("post_rst", 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);
    send_pkt(16'h00B1, 64'h500, 64'h5AB, 8, 1'b0);
    check_stats("recover", 32'd1, 32'hB1, 32'hAB, 32'd0, 32'hAB, 32'hAB, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
